uart_rx_frame_ctrl: RTL and testbench
=====================================

# uart_rx_frame_ctrl

Frame-level controller that sits directly behind the UART byte receiver. It gates the receiver, parses framed packets (SOF, length, payload, XOR checksum) from the received byte stream, and buffers the payload internally. Only checksum-verified payloads are released on a valid/ready byte stream to downstream logic. Breaks, length violations, checksum mismatches and inter-byte timeouts are reported as single-cycle error events.

## Interface
- CLK_HZ, 27_000_000, system clock frequency in Hz
- BIT_RATE, 9600, UART bit rate
- MAX_LEN, 16, maximum payload bytes per frame (buffer depth), 1..255
- SOF_BYTE, 8'hA5, start-of-frame marker
- TIMEOUT_BITS, 20, inter-byte timeout in bit periods; TIMEOUT_CYCLES = TIMEOUT_BITS*CLK_HZ/BIT_RATE (integer)

Ports:
- CLK_I  in  1  system clock
- RST_I  in  1  reset; **one clock; reset is synchronous and active-high**
- EN_I  in  1  controller enable
- RX_EN_O  out  1  receive enable to UART receiver
- RX_VLD_I  in  1  byte-valid pulse from receiver
- RX_D_I  in  8  received byte
- RX_BREAK_I  in  1  break indication (qualified by RX_VLD_I)
- M_DATA_O  out  8  payload byte out
- M_VLD_O  out  1  payload byte valid
- M_LAST_O  out  1  last payload byte of frame
- M_RDY_I  in  1  downstream ready
- FRAME_OK_O  out  1  one-cycle pulse: frame accepted
- FRAME_LEN_O  out  8  length of last accepted frame
- FRAME_ERR_O  out  1  one-cycle pulse: frame aborted
- ERR_CODE_O  out  2  0=BREAK, 1=LEN, 2=CHK, 3=TIMEOUT; meaningful only with FRAME_ERR_O
- OVR_O  out  1  one-cycle pulse: byte dropped while draining

## Operation
- RX_EN_O = registered EN_I.
- Byte accepted = RX_VLD_I && !RX_BREAK_I. Break = RX_VLD_I && RX_BREAK_I.
- FSM states: IDLE, LEN, PAYLOAD, CHK, DRAIN.
- IDLE: accepted byte == SOF_BYTE -> LEN; other bytes and breaks ignored.
- LEN: accepted byte L; clear checksum to L. L > MAX_LEN -> error LEN, IDLE. L == 0 -> CHK. Otherwise -> PAYLOAD.
- PAYLOAD: each accepted byte is written to buf[wr_idx], XORed into checksum, and wr_idx increments; after the L-th byte -> CHK.
- CHK: accepted byte == checksum -> FRAME_OK_O, FRAME_LEN_O <= L, then DRAIN (or IDLE if L == 0). Mismatch -> error CHK, IDLE.
- DRAIN: present buf[0..L-1] in order. M_LAST_O is set on index L-1. After the last handshake -> IDLE.
- Accepted byte or break while in DRAIN -> dropped, OVR_O pulse, no state change.
- Break in LEN/PAYLOAD/CHK -> error BREAK, IDLE.
- Timeout counter: cleared on entry to LEN and on every accepted byte; counts in LEN/PAYLOAD/CHK. Reaching TIMEOUT_CYCLES-1 -> error TIMEOUT, IDLE.
- EN_I low in LEN/PAYLOAD/CHK -> IDLE silently (no error pulse). EN_I low in IDLE holds IDLE. DRAIN always completes.
- Checksum and L are 8-bit. wr_idx/rd_idx width is $clog2(MAX_LEN+1). Buffer contents are not cleared between frames.

## Timing
- Reset values: RX_EN_O=0, M_DATA_O=0, M_VLD_O=0, M_LAST_O=0, FRAME_OK_O=0, FRAME_LEN_O=0, FRAME_ERR_O=0, ERR_CODE_O=0, OVR_O=0. FSM starts in IDLE with counters at 0. Reset mid-frame or mid-drain discards everything.
- All outputs are registered.
- FRAME_OK_O/FRAME_ERR_O/OVR_O assert exactly 1 cycle after the causing RX_VLD_I or timeout cycle.
- M_VLD_O rises in the same cycle as FRAME_OK_O, with M_DATA_O = buf[0].
- Stream rule: while M_VLD_O && !M_RDY_I, M_DATA_O, M_LAST_O and M_VLD_O are held. Transfer occurs on M_VLD_O && M_RDY_I. The next byte is presented the following cycle, giving 1 byte/cycle with M_RDY_I held high.
- M_VLD_O deasserts the cycle after the last transfer.
- Simultaneous accepted byte and timeout terminal count: the byte wins and the counter clears.
- Simultaneous EN_I fall and error condition: error pulse is reported.

## Test plan
- Good frame: bytes A5 03 11 22 33 03 with M_RDY_I=1 -> FRAME_OK_O pulse, FRAME_LEN_O=3, stream 11,22,33 on 3 consecutive cycles, M_LAST_O with 33.
- Backpressure: same frame, M_RDY_I toggling 1010… -> data held stable while not ready, all 3 bytes delivered in order. Extra byte 55 sent during DRAIN -> OVR_O pulse, stream unaffected.
- Checksum error: A5 02 10 20 31 -> FRAME_ERR_O, ERR_CODE_O=2, no M_VLD_O. Next good frame accepted normally.
- Length error: A5 11 (MAX_LEN=16) -> FRAME_ERR_O, ERR_CODE_O=1 one cycle after the length byte. Zero length A5 00 00 -> FRAME_OK_O, FRAME_LEN_O=0, no M_VLD_O.
- Timeout: A5 02 11 then idle line -> FRAME_ERR_O, ERR_CODE_O=3 exactly TIMEOUT_CYCLES after the 11 byte (56250 at defaults). A byte arriving one cycle before terminal count prevents the error.
- Break mid-payload: A5 04 01 then break -> FRAME_ERR_O, ERR_CODE_O=0. Assert RST_I during a later DRAIN -> all outputs 0 next cycle, FSM in IDLE.

Source files
------------

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl
// Frame parser that sits behind the UART byte receiver. It accepts SOF/length/payload/XOR-checksum
// frames and buffers the payload. Only checksum-verified payloads are streamed downstream.
// Breaks, bad lengths, bad checksums and inter-byte timeouts abort the frame with a one-cycle error pulse.
module uart_rx_frame_ctrl #(
  parameter int          CLK_HZ       = 27_000_000,
  parameter int          BIT_RATE     = 9600,
  parameter int          MAX_LEN      = 16,
  parameter logic [7:0]  SOF_BYTE     = 8'hA5,
  parameter int          TIMEOUT_BITS = 20
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       EN_I,
  output logic       RX_EN_O,
  input  logic       RX_VLD_I,
  input  logic [7:0] RX_D_I,
  input  logic       RX_BREAK_I,
  output logic [7:0] M_DATA_O,
  output logic       M_VLD_O,
  output logic       M_LAST_O,
  input  logic       M_RDY_I,
  output logic       FRAME_OK_O,
  output logic [7:0] FRAME_LEN_O,
  output logic       FRAME_ERR_O,
  output logic [1:0] ERR_CODE_O,
  output logic       OVR_O
);

  localparam longint TIMEOUT_CYCLES = longint'(TIMEOUT_BITS) * longint'(CLK_HZ) / longint'(BIT_RATE);
  localparam int     TOW            = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT_CYCLES - 1);
  localparam int     IDXW           = $clog2(MAX_LEN + 1);
  localparam int     ADDRW          = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int     BUF_DEPTH      = 1 << ADDRW;
  localparam logic [7:0] MAX_LEN_B  = 8'(MAX_LEN);

  localparam logic [1:0] ERR_BREAK   = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CHK     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {IDLE, LEN, PAYLOAD, CHK, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [7:0]      len_q, len_d;
  logic [7:0]      chk_q, chk_d;
  logic [IDXW-1:0] wrIdx_q, wrIdx_d;
  logic [IDXW-1:0] rdIdx_q, rdIdx_d;
  logic [TOW-1:0]  toCnt_q, toCnt_d;
  logic            rxEn_q;
  logic [7:0]      mData_q, mData_d;
  logic            mVld_q, mVld_d;
  logic            mLast_q, mLast_d;
  logic            frameOk_q, frameOk_d;
  logic [7:0]      frameLen_q, frameLen_d;
  logic            frameErr_q, frameErr_d;
  logic [1:0]      errCode_q, errCode_d;
  logic            ovr_q, ovr_d;

  logic [7:0]      bufMem [0:BUF_DEPTH-1];
  logic            bufWe;
  logic            rxAcc;
  logic            rxBrk;
  logic            toHit;

  assign rxAcc = RX_VLD_I && !RX_BREAK_I;
  assign rxBrk = RX_VLD_I && RX_BREAK_I;
  assign toHit = (toCnt_q == TO_LAST);

  // Payload buffer; contents survive between frames and only the written range is ever read
  always_ff @(posedge CLK_I) begin
    if (bufWe) bufMem[wrIdx_q[ADDRW-1:0]] <= RX_D_I;
  end

  // Next-state logic for the frame parser, the output stream and the event pulses
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    chk_d      = chk_q;
    wrIdx_d    = wrIdx_q;
    rdIdx_d    = rdIdx_q;
    toCnt_d    = toCnt_q;
    mData_d    = mData_q;
    mVld_d     = mVld_q;
    mLast_d    = mLast_q;
    frameOk_d  = 1'b0;
    frameLen_d = frameLen_q;
    frameErr_d = 1'b0;
    errCode_d  = errCode_q;
    ovr_d      = 1'b0;
    bufWe      = 1'b0;

    case (state_q)
      IDLE: begin
        toCnt_d = '0;
        wrIdx_d = '0;
        if (EN_I && rxAcc && (RX_D_I == SOF_BYTE)) state_d = LEN;
      end

      LEN, PAYLOAD, CHK: begin
        toCnt_d = toCnt_q + 1'b1;
        if (rxBrk) begin
          frameErr_d = 1'b1;
          errCode_d  = ERR_BREAK;
          state_d    = IDLE;
        end else if (rxAcc) begin
          toCnt_d = '0;
          if (state_q == LEN) begin
            len_d   = RX_D_I;
            chk_d   = RX_D_I;
            wrIdx_d = '0;
            if (RX_D_I > MAX_LEN_B) begin
              frameErr_d = 1'b1;
              errCode_d  = ERR_LEN;
              state_d    = IDLE;
            end else if (RX_D_I == 8'd0) begin
              state_d = CHK;
            end else begin
              state_d = PAYLOAD;
            end
          end else if (state_q == PAYLOAD) begin
            bufWe   = 1'b1;
            chk_d   = chk_q ^ RX_D_I;
            wrIdx_d = wrIdx_q + 1'b1;
            if (8'(wrIdx_q + 1'b1) == len_q) state_d = CHK;
          end else begin
            if (RX_D_I == chk_q) begin
              frameOk_d  = 1'b1;
              frameLen_d = len_q;
              if (len_q == 8'd0) begin
                state_d = IDLE;
              end else begin
                state_d = DRAIN;
                mVld_d  = 1'b1;
                mData_d = bufMem[0];
                mLast_d = (len_q == 8'd1);
                rdIdx_d = IDXW'(1);
              end
            end else begin
              frameErr_d = 1'b1;
              errCode_d  = ERR_CHK;
              state_d    = IDLE;
            end
          end
        end else if (toHit) begin
          frameErr_d = 1'b1;
          errCode_d  = ERR_TIMEOUT;
          state_d    = IDLE;
        end

        if (!EN_I && !frameErr_d) begin
          state_d    = IDLE;
          frameOk_d  = 1'b0;
          frameLen_d = frameLen_q;
          mVld_d     = 1'b0;
          mLast_d    = 1'b0;
          mData_d    = mData_q;
        end
      end

      DRAIN: begin
        if (RX_VLD_I) ovr_d = 1'b1;
        if (mVld_q && M_RDY_I) begin
          if (mLast_q) begin
            mVld_d  = 1'b0;
            mLast_d = 1'b0;
            state_d = IDLE;
          end else begin
            mData_d = bufMem[rdIdx_q[ADDRW-1:0]];
            mLast_d = ((8'(rdIdx_q) + 8'd1) == len_q);
            rdIdx_d = rdIdx_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset discards any frame in flight
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q    <= IDLE;
      len_q      <= '0;
      chk_q      <= '0;
      wrIdx_q    <= '0;
      rdIdx_q    <= '0;
      toCnt_q    <= '0;
      rxEn_q     <= 1'b0;
      mData_q    <= '0;
      mVld_q     <= 1'b0;
      mLast_q    <= 1'b0;
      frameOk_q  <= 1'b0;
      frameLen_q <= '0;
      frameErr_q <= 1'b0;
      errCode_q  <= '0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      chk_q      <= chk_d;
      wrIdx_q    <= wrIdx_d;
      rdIdx_q    <= rdIdx_d;
      toCnt_q    <= toCnt_d;
      rxEn_q     <= EN_I;
      mData_q    <= mData_d;
      mVld_q     <= mVld_d;
      mLast_q    <= mLast_d;
      frameOk_q  <= frameOk_d;
      frameLen_q <= frameLen_d;
      frameErr_q <= frameErr_d;
      errCode_q  <= errCode_d;
      ovr_q      <= ovr_d;
    end
  end

  assign RX_EN_O     = rxEn_q;
  assign M_DATA_O    = mData_q;
  assign M_VLD_O     = mVld_q;
  assign M_LAST_O    = mLast_q;
  assign FRAME_OK_O  = frameOk_q;
  assign FRAME_LEN_O = frameLen_q;
  assign FRAME_ERR_O = frameErr_q;
  assign ERR_CODE_O  = errCode_q;
  assign OVR_O       = ovr_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl
// Directed bench for the UART frame controller: a vector table for the byte-level
// behaviour plus hand-written sequences for maximum length, timeout, enable drop and reset.
module tb_uart_rx_frame_ctrl;

  localparam int CLK_HZ       = 96_000;
  localparam int BIT_RATE     = 9600;
  localparam int MAX_LEN      = 16;
  localparam int TIMEOUT_BITS = 20;
  localparam int TCYC         = TIMEOUT_BITS * CLK_HZ / BIT_RATE;

  logic       clk = 1'b0;
  logic       RST_I, EN_I, RX_VLD_I, RX_BREAK_I, M_RDY_I;
  logic [7:0] RX_D_I;
  logic       RX_EN_O, M_VLD_O, M_LAST_O, FRAME_OK_O, FRAME_ERR_O, OVR_O;
  logic [7:0] M_DATA_O, FRAME_LEN_O;
  logic [1:0] ERR_CODE_O;

  int   compared   = 0;
  int   mismatched = 0;
  logic expRxEn    = 1'b0;

  typedef struct {
    logic       en, vld, brk, rdy;
    logic [7:0] d;
    logic       ok, err;
    logic [1:0] code;
    logic       ovld;
    logic [7:0] odata;
    logic       olast, ovr;
    logic [7:0] len;
  } vec_t;

  vec_t vecs[$];

  uart_rx_frame_ctrl #(
    .CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE), .MAX_LEN(MAX_LEN),
    .SOF_BYTE(8'hA5), .TIMEOUT_BITS(TIMEOUT_BITS)
  ) dut (
    .CLK_I(clk), .RST_I(RST_I), .EN_I(EN_I), .RX_EN_O(RX_EN_O),
    .RX_VLD_I(RX_VLD_I), .RX_D_I(RX_D_I), .RX_BREAK_I(RX_BREAK_I),
    .M_DATA_O(M_DATA_O), .M_VLD_O(M_VLD_O), .M_LAST_O(M_LAST_O), .M_RDY_I(M_RDY_I),
    .FRAME_OK_O(FRAME_OK_O), .FRAME_LEN_O(FRAME_LEN_O), .FRAME_ERR_O(FRAME_ERR_O),
    .ERR_CODE_O(ERR_CODE_O), .OVR_O(OVR_O)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Safety net so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, required to have finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic addVec(input logic vld, brk, rdy, input logic [7:0] d,
                        input logic ok, err, input logic [1:0] code,
                        input logic ovld, input logic [7:0] odata,
                        input logic olast, ovr, input logic [7:0] len);
    vec_t v;
    v.en = 1'b1; v.vld = vld; v.brk = brk; v.rdy = rdy; v.d = d;
    v.ok = ok; v.err = err; v.code = code; v.ovld = ovld; v.odata = odata;
    v.olast = olast; v.ovr = ovr; v.len = len;
    vecs.push_back(v);
  endtask

  // Plain byte that must produce no event and no stream output
  task automatic zb(input logic [7:0] d, input logic [7:0] len);
    addVec(1'b1, 1'b0, 1'b1, d, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, len);
  endtask

  // Called at a falling edge: drive inputs, let one rising edge pass, return at the next falling edge
  task automatic applyStimulus(input logic en, vld, brk, rdy, input logic [7:0] d);
    EN_I = en; RX_VLD_I = vld; RX_BREAK_I = brk; M_RDY_I = rdy; RX_D_I = d;
    @(posedge clk);
    expRxEn = en;
    @(negedge clk);
  endtask

  task automatic sendByte(input logic [7:0] d, input logic rdy);
    applyStimulus(1'b1, 1'b1, 1'b0, rdy, d);
  endtask

  task automatic idleCyc(input logic rdy);
    applyStimulus(1'b1, 1'b0, 1'b0, rdy, 8'h00);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Packs {RX_EN, OK, ERR, CODE, VLD, DATA, LAST, OVR, LEN}; CODE and DATA only matter when flagged
  task automatic expectOut(input string name, input logic ok, err, input logic [1:0] code,
                           input logic vld, input logic [7:0] data, input logic last, ovr,
                           input logic [7:0] len);
    logic [23:0] a, e;
    a = {RX_EN_O, FRAME_OK_O, FRAME_ERR_O, err ? ERR_CODE_O : 2'b00, M_VLD_O,
         vld ? M_DATA_O : 8'h00, M_LAST_O, OVR_O, FRAME_LEN_O};
    e = {expRxEn, ok, err, err ? code : 2'b00, vld, vld ? data : 8'h00, last, ovr, len};
    checkOutput(name, 32'(a), 32'(e));
  endtask

  initial begin
    logic [7:0] payload [0:15];
    logic [7:0] chk;
    int         early;

    // ---- vector table ----
    addVec(1,0,1,8'h5A, 0,0,0, 0,8'h00,0,0, 8'd0);   // junk in IDLE
    addVec(1,1,1,8'hA5, 0,0,0, 0,8'h00,0,0, 8'd0);   // break carrying SOF value in IDLE
    zb(8'hA5,0); zb(8'h03,0); zb(8'h11,0); zb(8'h22,0); zb(8'h33,0);
    addVec(1,0,1,8'h03, 1,0,0, 1,8'h11,0,0, 8'd3);
    addVec(0,0,1,8'h00, 0,0,0, 1,8'h22,0,0, 8'd3);
    addVec(0,0,1,8'h00, 0,0,0, 1,8'h33,1,0, 8'd3);
    addVec(0,0,1,8'h00, 0,0,0, 0,8'h00,0,0, 8'd3);
    zb(8'hA5,3); zb(8'h03,3); zb(8'h11,3); zb(8'h22,3); zb(8'h33,3);
    addVec(1,0,0,8'h03, 1,0,0, 1,8'h11,0,0, 8'd3);
    addVec(0,0,1,8'h00, 0,0,0, 1,8'h22,0,0, 8'd3);
    addVec(1,0,0,8'h55, 0,0,0, 1,8'h22,0,1, 8'd3);   // overrun while stalled
    addVec(0,0,1,8'h00, 0,0,0, 1,8'h33,1,0, 8'd3);
    addVec(1,1,0,8'h00, 0,0,0, 1,8'h33,1,1, 8'd3);   // break during drain is an overrun too
    addVec(0,0,1,8'h00, 0,0,0, 0,8'h00,0,0, 8'd3);
    zb(8'hA5,3); zb(8'h02,3); zb(8'h10,3); zb(8'h20,3);
    addVec(1,0,1,8'h31, 0,1,2, 0,8'h00,0,0, 8'd3);   // checksum error
    addVec(0,0,1,8'h00, 0,0,0, 0,8'h00,0,0, 8'd3);
    zb(8'hA5,3); zb(8'h01,3); zb(8'h7E,3);
    addVec(1,0,1,8'h7F, 1,0,0, 1,8'h7E,1,0, 8'd1);   // single-byte frame is last immediately
    addVec(0,0,1,8'h00, 0,0,0, 0,8'h00,0,0, 8'd1);
    zb(8'hA5,1);
    addVec(1,0,1,8'h11, 0,1,1, 0,8'h00,0,0, 8'd1);   // length 17 > MAX_LEN
    zb(8'h00,1);
    zb(8'hA5,1); zb(8'h00,1);
    addVec(1,0,1,8'h00, 1,0,0, 0,8'h00,0,0, 8'd0);   // zero-length frame
    addVec(0,0,1,8'h00, 0,0,0, 0,8'h00,0,0, 8'd0);
    zb(8'hA5,0); zb(8'h04,0); zb(8'h01,0);
    addVec(1,1,1,8'h00, 0,1,0, 0,8'h00,0,0, 8'd0);   // break mid-payload
    addVec(0,0,1,8'h00, 0,0,0, 0,8'h00,0,0, 8'd0);

    // ---- reset ----
    RST_I = 1'b1; EN_I = 1'b0; RX_VLD_I = 1'b0; RX_BREAK_I = 1'b0; M_RDY_I = 1'b0; RX_D_I = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    expRxEn = 1'b0;
    expectOut("reset", 0,0,2'd0, 0,8'h00,0,0, 8'd0);
    checkOutput("reset_data", 32'(M_DATA_O), 32'h0);
    checkOutput("reset_code", 32'(ERR_CODE_O), 32'h0);
    RST_I = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].en, vecs[i].vld, vecs[i].brk, vecs[i].rdy, vecs[i].d);
      expectOut($sformatf("vec%0d", i), vecs[i].ok, vecs[i].err, vecs[i].code,
                vecs[i].ovld, vecs[i].odata, vecs[i].olast, vecs[i].ovr, vecs[i].len);
    end

    // ---- maximum length frame (16 bytes) ----
    sendByte(8'hA5, 1'b1);
    sendByte(8'h10, 1'b1);
    chk = 8'h10;
    for (int i = 0; i < 16; i++) begin
      payload[i] = 8'(i * 7 + 3);
      chk = chk ^ payload[i];
      sendByte(payload[i], 1'b1);
    end
    expectOut("maxlen_payload", 0,0,2'd0, 0,8'h00,0,0, 8'd0);
    sendByte(chk, 1'b1);
    expectOut("maxlen_ok", 1,0,2'd0, 1,payload[0],0,0, 8'd16);
    for (int i = 1; i < 16; i++) begin
      idleCyc(1'b1);
      expectOut($sformatf("maxlen_data%0d", i), 0,0,2'd0, 1,payload[i], (i == 15),0, 8'd16);
    end
    idleCyc(1'b1);
    expectOut("maxlen_end", 0,0,2'd0, 0,8'h00,0,0, 8'd16);

    // ---- timeout: error exactly TCYC cycles after the last byte ----
    sendByte(8'hA5, 1'b1); sendByte(8'h02, 1'b1); sendByte(8'h11, 1'b1);
    expectOut("to_start", 0,0,2'd0, 0,8'h00,0,0, 8'd16);
    early = 0;
    for (int k = 1; k < TCYC; k++) begin
      idleCyc(1'b1);
      if (FRAME_ERR_O) early++;
    end
    checkOutput("to_quiet", 32'(early), 32'd0);
    idleCyc(1'b1);
    expectOut("to_err", 0,1,2'd3, 0,8'h00,0,0, 8'd16);
    idleCyc(1'b1);
    expectOut("to_after", 0,0,2'd0, 0,8'h00,0,0, 8'd16);

    // ---- byte arriving on the terminal-count cycle wins ----
    sendByte(8'hA5, 1'b1); sendByte(8'h02, 1'b1); sendByte(8'h11, 1'b1);
    early = 0;
    for (int k = 1; k < TCYC; k++) begin
      idleCyc(1'b1);
      if (FRAME_ERR_O) early++;
    end
    checkOutput("tc_quiet", 32'(early), 32'd0);
    sendByte(8'h22, 1'b1);
    expectOut("tc_byte_wins", 0,0,2'd0, 0,8'h00,0,0, 8'd16);
    sendByte(8'h31, 1'b1);
    expectOut("tc_ok", 1,0,2'd0, 1,8'h11,0,0, 8'd2);
    idleCyc(1'b1);
    expectOut("tc_data1", 0,0,2'd0, 1,8'h22,1,0, 8'd2);
    idleCyc(1'b1);
    expectOut("tc_end", 0,0,2'd0, 0,8'h00,0,0, 8'd2);

    // ---- enable dropped mid-frame: silent abort ----
    sendByte(8'hA5, 1'b1); sendByte(8'h02, 1'b1); sendByte(8'h11, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    expectOut("en_drop", 0,0,2'd0, 0,8'h00,0,0, 8'd2);
    sendByte(8'h22, 1'b1);
    expectOut("en_drop_idle", 0,0,2'd0, 0,8'h00,0,0, 8'd2);
    sendByte(8'h31, 1'b1);
    expectOut("en_drop_no_ok", 0,0,2'd0, 0,8'h00,0,0, 8'd2);

    // ---- reset during drain ----
    sendByte(8'hA5, 1'b0); sendByte(8'h03, 1'b0); sendByte(8'h11, 1'b0);
    sendByte(8'h22, 1'b0); sendByte(8'h33, 1'b0); sendByte(8'h03, 1'b0);
    expectOut("rst_ok", 1,0,2'd0, 1,8'h11,0,0, 8'd3);
    idleCyc(1'b0);
    expectOut("rst_hold", 0,0,2'd0, 1,8'h11,0,0, 8'd3);
    RST_I = 1'b1;
    idleCyc(1'b1);
    expRxEn = 1'b0;
    RST_I = 1'b0;
    expectOut("rst_drain", 0,0,2'd0, 0,8'h00,0,0, 8'd0);
    checkOutput("rst_drain_data", 32'(M_DATA_O), 32'h0);
    idleCyc(1'b1);
    expectOut("rst_quiet", 0,0,2'd0, 0,8'h00,0,0, 8'd0);
    sendByte(8'hA5, 1'b1); sendByte(8'h00, 1'b1);
    sendByte(8'h00, 1'b1);
    expectOut("rst_next_frame", 1,0,2'd0, 0,8'h00,0,0, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
